// File: rtl/rvx_uart_tx_fifo.sv
// rvx_uart_tx_fifo: byte transmit buffer placed in front of rvx_uart.
// The CPU pushes bytes through the slave register port; a small master FSM
// polls the UART status register and hands each byte over once the UART
// reports ready-to-send.
// Optional feature: define RVX_UART_TX_FIFO_IRQ_EN to build the drain-complete
// interrupt on fifo_irq; otherwise fifo_irq is tied low.

`ifndef RVX_UART_WRITE_REG_ADDR
`define RVX_UART_WRITE_REG_ADDR 5'h00
`endif
`ifndef RVX_UART_STATUS_REG_ADDR
`define RVX_UART_STATUS_REG_ADDR 5'h08
`endif

module rvx_uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  // slave side (CPU)
  input  logic [4:0]  rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  // master side (rvx_uart)
  output logic [4:0]  uart_rw_address,
  input  logic [31:0] uart_read_data,
  output logic        uart_read_request,
  input  logic        uart_read_response,
  output logic [31:0] uart_write_data,
  output logic [3:0]  uart_write_strobe,
  output logic        uart_write_request,
  input  logic        uart_write_response,
  output logic        fifo_irq
);

  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam int         LEVEL_W     = DEPTH_LOG2 + 1;
  localparam logic [4:0] DATA_ADDR   = 5'h00;
  localparam logic [4:0] STATUS_ADDR = 5'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_WAIT_STAT,
    S_SEND,
    S_WAIT_WR
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [LEVEL_W-1:0]    r_level;
  logic                  r_overflow;
  logic [31:0]           r_read_data;
  logic                  r_read_response;
  logic                  r_write_response;
  logic [4:0]            r_uart_addr;
  logic [4:0]            w_uart_addr_next;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_strobe_ok;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_status_rd;
  logic [7:0]            w_level_byte;
  logic [31:0]           w_status;
  logic                  w_unused;

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == LEVEL_W'(DEPTH));
  assign w_strobe_ok = (write_strobe == 4'b1111) || (write_strobe == 4'b0011) ||
                       (write_strobe == 4'b0001);
  // A DATA write with a legal strobe is a push attempt; it lands only if not full.
  assign w_push_req  = write_request && (rw_address == DATA_ADDR) && w_strobe_ok;
  assign w_push      = w_push_req && !w_full;
  // Only the FSM pops, and it only reaches WAIT_WR with a byte at the head.
  assign w_pop       = (r_state == S_WAIT_WR) && uart_write_response;
  assign w_status_rd = read_request && (rw_address == STATUS_ADDR);

  // Level lives in bits [7:0]; bit 7 only overlaps it when the FIFO is
  // non-empty, so the empty flag and the level never collide.
  assign w_level_byte = 8'(r_level);
  assign w_status     = {22'b0, r_overflow, w_full, w_empty, 7'b0} | {24'b0, w_level_byte};

  // Upper data bits carry nothing for a byte-wide transmit path.
  assign w_unused = ^{write_data[31:8], uart_read_data[31:1]};

  // Slave port: every request answered one cycle later, read data latched with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_read_response  <= 1'b0;
      r_write_response <= 1'b0;
      r_read_data      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      r_read_response  <= read_request;
      r_write_response <= write_request;
      r_read_data      <= w_status_rd ? w_status : '0;
    end
  end

  // FIFO bookkeeping: pointers, level counter and sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LEVEL_W'(1);
        2'b01:   r_level <= r_level - LEVEL_W'(1);
        default: r_level <= r_level;
      endcase
      // A fresh overflow beats a simultaneous STATUS read so it is never lost.
      if (w_push_req && w_full) r_overflow <= 1'b1;
      else if (w_status_rd)     r_overflow <= 1'b0;
    end
  end

  // Byte storage, written on accepted pushes.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; the level counter alone decides
    // which entries are valid, so clearing it would only cost area.
    if (w_push) r_mem[r_wr_ptr] <= write_data[7:0];
  end

  // Master FSM state and the held UART address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_uart_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_uart_addr <= w_uart_addr_next;
    end
  end

  // Master FSM next state; the address is loaded on entry to POLL/SEND.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    w_state_next     = r_state;
    w_uart_addr_next = r_uart_addr;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_next     = S_POLL;
          w_uart_addr_next = `RVX_UART_STATUS_REG_ADDR;
        end
      end
      S_POLL: w_state_next = S_WAIT_STAT;
      S_WAIT_STAT: begin
        if (uart_read_response) begin
          if (uart_read_data[0]) begin
            w_state_next     = S_SEND;
            w_uart_addr_next = `RVX_UART_WRITE_REG_ADDR;
          end else begin
            w_state_next     = S_POLL;
            w_uart_addr_next = `RVX_UART_STATUS_REG_ADDR;
          end
        end
      end
      S_SEND: w_state_next = S_WAIT_WR;
      S_WAIT_WR: begin
        if (uart_write_response) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign read_data          = r_read_data;
  assign read_response      = r_read_response;
  assign write_response     = r_write_response;
  assign uart_rw_address    = r_uart_addr;
  assign uart_read_request  = (r_state == S_POLL);
  assign uart_write_request = (r_state == S_SEND);
  assign uart_write_data    = (r_state == S_SEND) ? {24'b0, r_mem[r_rd_ptr]} : '0;
  assign uart_write_strobe  = 4'b0001;

`ifdef RVX_UART_TX_FIFO_IRQ_EN
  logic r_irq;

  // Drain-complete interrupt: set when the last byte is handed off, cleared
  // by any DATA push or STATUS read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else if (w_pop && (r_level == LEVEL_W'(1)) && !w_push_req) begin
      r_irq <= 1'b1;
    end else if (w_push_req || w_status_rd) begin
      r_irq <= 1'b0;
    end
  end

  assign fifo_irq = r_irq;
`else
  assign fifo_irq = 1'b0;
`endif

endmodule

// File: tb/tb_rvx_uart_tx_fifo.sv
// Self-checking bench for rvx_uart_tx_fifo: table-driven slave accesses plus
// hand-written drain, overflow, timing and reset sequences against a
// registered rvx_uart stub.

module tb_rvx_uart_tx_fifo;

  localparam logic [4:0] A_DATA   = 5'h00;
  localparam logic [4:0] A_STATUS = 5'h04;
  localparam logic [4:0] U_WRITE  = 5'h00;
  localparam logic [4:0] U_STATUS = 5'h08;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  rw_address;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;
  logic [4:0]  uart_rw_address;
  logic [31:0] uart_read_data;
  logic        uart_read_request;
  logic        uart_read_response;
  logic [31:0] uart_write_data;
  logic [3:0]  uart_write_strobe;
  logic        uart_write_request;
  logic        uart_write_response;
  logic        fifo_irq;

  rvx_uart_tx_fifo dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .rw_address          (rw_address),
    .read_data           (read_data),
    .read_request        (read_request),
    .read_response       (read_response),
    .write_data          (write_data),
    .write_strobe        (write_strobe),
    .write_request       (write_request),
    .write_response      (write_response),
    .uart_rw_address     (uart_rw_address),
    .uart_read_data      (uart_read_data),
    .uart_read_request   (uart_read_request),
    .uart_read_response  (uart_read_response),
    .uart_write_data     (uart_write_data),
    .uart_write_strobe   (uart_write_strobe),
    .uart_write_request  (uart_write_request),
    .uart_write_response (uart_write_response),
    .fifo_irq            (fifo_irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int push_cyc = 0;

  // UART stub state
  logic      stub_ready = 1'b0;
  int        poll_cnt;
  int        stub_bad = 0;
  logic [7:0] cap_q[$];
  int        cap_cyc[$];
  int        cap_polls[$];

  always @(posedge clock) cyc <= cyc + 1;

  // rvx_uart stub: 1-cycle registered responses, status bit0 = stub_ready,
  // records each byte written along with its cycle and preceding poll count.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uart_read_response  <= 1'b0;
      uart_write_response <= 1'b0;
      uart_read_data      <= '0;
      poll_cnt            <= 0;
    end else begin
      uart_read_response  <= uart_read_request;
      uart_write_response <= uart_write_request;
      uart_read_data      <= uart_read_request ? {31'b0, stub_ready} : 32'h0;
      if (uart_read_request) begin
        poll_cnt <= poll_cnt + 1;
        if (uart_rw_address != U_STATUS) stub_bad <= stub_bad + 1;
      end
      if (uart_write_request) begin
        cap_q.push_back(uart_write_data[7:0]);
        cap_cyc.push_back(cyc);
        cap_polls.push_back(poll_cnt);
        poll_cnt <= 0;
        if (uart_rw_address != U_WRITE || uart_write_strobe != 4'b0001 ||
            uart_write_data[31:8] != 24'h0)
          stub_bad <= stub_bad + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic resp);
    @(negedge clock);
    rw_address    = a;
    write_data    = d;
    write_strobe  = s;
    write_request = 1'b1;
    @(negedge clock);
    write_request = 1'b0;
    resp          = write_response;
    push_cyc      = cyc - 1;
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic resp);
    @(negedge clock);
    rw_address   = a;
    read_request = 1'b1;
    @(negedge clock);
    read_request = 1'b0;
    d            = read_data;
    resp         = read_response;
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    logic        r;
    do_read(A_STATUS, d, r);
    check(name, d, exp);
  endtask

  // Wait (bounded) until n bytes have reached the stub, then let the pop land.
  task automatic wait_caps(input int n, input int budget);
    int k = 0;
    while (cap_q.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("drain_count", cap_q.size(), n);
    @(negedge clock);
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;   // read data for reads, write_response for writes
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] d;
    logic        r;
    int          base;
    int          bad;

    vecs[0]  = '{1'b0, A_STATUS, 32'h0,         4'h0, 32'h0000_0080};
    vecs[1]  = '{1'b0, A_DATA,   32'h0,         4'h0, 32'h0000_0000};
    vecs[2]  = '{1'b0, 5'h1C,    32'h0,         4'h0, 32'h0000_0000};
    vecs[3]  = '{1'b1, A_DATA,   32'h0000_0041, 4'b0010, 32'h1};
    vecs[4]  = '{1'b0, A_STATUS, 32'h0,         4'h0, 32'h0000_0080};
    vecs[5]  = '{1'b1, A_DATA,   32'h0000_00AA, 4'b0011, 32'h1};
    vecs[6]  = '{1'b0, A_STATUS, 32'h0,         4'h0, 32'h0000_0001};
    vecs[7]  = '{1'b1, A_DATA,   32'h1234_55BB, 4'b1111, 32'h1};
    vecs[8]  = '{1'b1, A_DATA,   32'h0000_0077, 4'b0001, 32'h1};
    vecs[9]  = '{1'b1, A_STATUS, 32'h0000_00FF, 4'b1111, 32'h1};
    vecs[10] = '{1'b0, A_STATUS, 32'h0,         4'h0, 32'h0000_0003};
    vecs[11] = '{1'b1, A_DATA,   32'h0000_0099, 4'b0100, 32'h1};
    vecs[12] = '{1'b0, A_STATUS, 32'h0,         4'h0, 32'h0000_0003};

    reset_n       = 1'b0;
    rw_address    = '0;
    read_request  = 1'b0;
    write_data    = '0;
    write_strobe  = '0;
    write_request = 1'b0;
    repeat (3) @(negedge clock);

    // Outputs during reset
    check("rst_read_data",   read_data, 32'h0);
    check("rst_read_resp",   {31'b0, read_response}, 32'h0);
    check("rst_write_resp",  {31'b0, write_response}, 32'h0);
    check("rst_uart_rd_req", {31'b0, uart_read_request}, 32'h0);
    check("rst_uart_wr_req", {31'b0, uart_write_request}, 32'h0);
    check("rst_uart_addr",   {27'b0, uart_rw_address}, 32'h0);
    check("rst_uart_wdata",  uart_write_data, 32'h0);
    check("rst_irq",         {31'b0, fifo_irq}, 32'h0);
    reset_n = 1'b1;

    do_read(A_STATUS, d, r);
    check("status_after_reset", d, 32'h0000_0080);
    check("read_resp", {31'b0, r}, 32'h1);

    // Single byte, UART ready on first poll: stub sees the write 4 edges
    // after the push edge, the pop lands on the 5th.
    stub_ready = 1'b1;
    do_write(A_DATA, 32'h0000_0041, 4'b0001, r);
    check("push41_resp", {31'b0, r}, 32'h1);
    wait_caps(1, 40);
    if (cap_q.size() >= 1) begin
      check("byte41_data",  {24'b0, cap_q[0]}, 32'h41);
      check("byte41_lat",   cap_cyc[0] - push_cyc, 4);
      check("byte41_polls", cap_polls[0], 1);
    end
    read_status("status_after_41", 32'h0000_0080);

    // Table of register accesses with the UART busy
    stub_ready = 1'b0;
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, r);
        check($sformatf("vec%0d_wresp", i), {31'b0, r}, vecs[i].exp);
      end else begin
        do_read(vecs[i].addr, d, r);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
      end
    end
    check("busy_no_send", cap_q.size(), 1);
    base = cap_q.size();
    stub_ready = 1'b1;
    wait_caps(base + 3, 100);
    if (cap_q.size() >= base + 3) begin
      check("tbl_byte0", {24'b0, cap_q[base]},     32'hAA);
      check("tbl_byte1", {24'b0, cap_q[base + 1]}, 32'hBB);
      check("tbl_byte2", {24'b0, cap_q[base + 2]}, 32'h77);
    end
    read_status("status_tbl_drained", 32'h0000_0080);

    // Fill to full while busy, then overflow
    stub_ready = 1'b0;
    for (int i = 0; i < 16; i++) do_write(A_DATA, i, 4'b0001, r);
    read_status("status_full", 32'h0000_0110);
    do_write(A_DATA, 32'h0000_00FF, 4'b0001, r);
    check("push_full_resp", {31'b0, r}, 32'h1);
    read_status("status_overflow", 32'h0000_0310);
    read_status("status_ovf_cleared", 32'h0000_0110);

    base = cap_q.size();
    stub_ready = 1'b1;
    wait_caps(base + 16, 300);
    if (cap_q.size() >= base + 16) begin
      for (int i = 0; i < 16; i++)
        check($sformatf("full_byte%0d", i), {24'b0, cap_q[base + i]}, i);
      bad = 0;
      for (int i = 1; i < 16; i++)
        if (cap_cyc[base + i] - cap_cyc[base + i - 1] != 5) bad++;
      check("handoff_5_cycles", bad, 0);
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (cap_polls[base + i] < 1) bad++;
      check("poll_before_write", bad, 0);
    end
    read_status("status_full_drained", 32'h0000_0080);

    // Back-to-back pushes while draining: some pushes share the pop edge
    base = cap_q.size();
    for (int i = 0; i < 6; i++) do_write(A_DATA, 32'h60 + i, 4'b1111, r);
    wait_caps(base + 6, 100);
    if (cap_q.size() >= base + 6) begin
      bad = 0;
      for (int i = 0; i < 6; i++)
        if (cap_q[base + i] != 8'(8'h60 + i)) bad++;
      check("pushpop_order", bad, 0);
    end
`ifdef RVX_UART_TX_FIFO_IRQ_EN
    check("irq_set_on_drain", {31'b0, fifo_irq}, 32'h1);
    read_status("status_pushpop_drained", 32'h0000_0080);
    check("irq_cleared_by_status", {31'b0, fifo_irq}, 32'h0);
`else
    check("irq_tied_low", {31'b0, fifo_irq}, 32'h0);
    read_status("status_pushpop_drained", 32'h0000_0080);
`endif

    // Reset while SEND is on the bus
    base = cap_q.size();
    do_write(A_DATA, 32'h0000_005A, 4'b0001, r);
    bad = 0;
    while (!uart_write_request && bad < 20) begin
      @(negedge clock);
      bad++;
    end
    check("reached_send", {31'b0, uart_write_request}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrst_wr_req", {31'b0, uart_write_request}, 32'h0);
    check("midrst_rd_req", {31'b0, uart_read_request}, 32'h0);
    check("midrst_wdata",  uart_write_data, 32'h0);
    check("midrst_addr",   {27'b0, uart_rw_address}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    read_status("status_after_midrst", 32'h0000_0080);
    repeat (10) @(negedge clock);
    check("midrst_byte_dropped", cap_q.size(), base);

    check("stub_protocol", stub_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
